// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory controller between the CPU load/store path and an internal
// byte-lane RAM. CPU byte addresses are rebased against BASE_ADDR. The
// controller supports byte, halfword and word accesses, with sign or zero
// extension on reads. A req/ready handshake adds WAIT_CYCLES wait states.
// Misaligned, out-of-range and reserved-size accesses are rejected and flagged.
// They are not wrapped into the array.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous reset, active low
//   req       in   access request, sampled only while idle
//   we        in   1 = write, 0 = read
//   size      in   00 byte, 01 half, 10 word, 11 reserved (error)
//   sign_ext  in   read extension select for byte/half
//   addr      in   CPU byte address
//   wdata     in   right-aligned write data
//   rdata     out  read result, valid with ready, held until next ready
//   ready     out  one-cycle completion pulse
//   busy      out  access in flight
//   addr_err  out  access rejected (valid with ready)
//   word_idx  out  word index of current/last access
//   err_cnt   out  saturating count of rejected accesses
// -----------------------------------------------------------------------------
module dmem_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH_WORDS = 2048,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          WAIT_CYCLES = 1,
    localparam int         AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ready,
    output logic              busy,
    output logic              addr_err,
    output logic [AW-1:0]     word_idx,
    output logic [7:0]        err_cnt
);

    localparam int          LANES     = DATA_W / 8;
    // Byte size of the array. It is 33 bits wide so that a 4 GiB depth
    // cannot overflow the bound.
    localparam logic [32:0] LIMIT     = 33'(DEPTH_WORDS) << 2;
    localparam logic [2:0]  WAIT_LAST = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      wait_cnt_q, wait_cnt_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            sext_q, sext_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [1:0]      lane_q, lane_d;
    logic [AW-1:0]   word_idx_q, word_idx_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic [31:0]     off;
    logic            acc_err;
    logic [AW-1:0]   rd_idx;
    logic            wr_en;
    logic [LANES-1:0] lane_be;
    logic [31:0]     wr_word;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;
    logic [15:0]     rd_half;
    logic [31:0]     rd_fmt;
    logic            rd_present;

    // ------------------------------------------------------------------
    // Address translation and accept-time error classification
    // ------------------------------------------------------------------
    always_comb begin
        off     = addr - BASE_ADDR;
        acc_err = 1'b0;
        if ({1'b0, off} >= LIMIT) begin
            acc_err = 1'b1;
        end
        case (size)
            2'b01:   if (off[0])          acc_err = 1'b1;
            2'b10:   if (off[1:0] != 2'b00) acc_err = 1'b1;
            2'b11:   acc_err = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register and latched access context
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 3'd0;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            sext_q     <= 1'b0;
            wdata_q    <= 32'd0;
            lane_q     <= 2'b00;
            word_idx_q <= '0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            err_cnt_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            sext_q     <= sext_d;
            wdata_q    <= wdata_d;
            lane_q     <= lane_d;
            word_idx_q <= word_idx_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        we_d       = we_q;
        size_d     = size_q;
        sext_d     = sext_q;
        wdata_d    = wdata_q;
        lane_d     = lane_q;
        word_idx_d = word_idx_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        err_cnt_d  = err_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
                    wait_cnt_d = WAIT_LAST;
                    we_d       = we;
                    size_d     = size;
                    sext_d     = sign_ext;
                    wdata_d    = wdata;
                    lane_d     = off[1:0];
                    word_idx_d = off[AW+1:2];
                    err_d      = acc_err;
                end
            end
            S_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                // Reads and rejected accesses refresh the held result.
                // A good write leaves the previous read value in place.
                if (rd_present) begin
                    rdata_d = rd_fmt;
                end
                if (err_q && (err_cnt_q != 8'hFF)) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // RAM port control
    // ------------------------------------------------------------------
    // While idle the RAM is addressed straight from the CPU address. This
    // lets a zero-wait access have its word ready on entry to DONE. Later
    // cycles use the latched index.
    assign rd_idx = (state_q == S_IDLE) ? off[AW+1:2] : word_idx_q;

    // A write commits on the edge that ends DONE. Gating with rst keeps a
    // reset on that same edge from committing the write.
    assign wr_en = (state_q == S_DONE) && we_q && !err_q && rst;

    always_comb begin
        lane_be = '0;
        wr_word = wdata_q;
        case (size_q)
            2'b00: begin
                lane_be = LANES'(1) << lane_q;
                wr_word = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_be = lane_q[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                lane_be = '1;
                wr_word = wdata_q;
            end
            default: begin
                lane_be = '0;
                wr_word = wdata_q;
            end
        endcase
    end

    // One byte-wide array per lane. Each lane has its own write enable and
    // a registered read.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem_q [DEPTH_WORDS];
            logic [7:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en && lane_be[gi]) begin
                    mem_q[word_idx_q] <= wr_word[8*gi +: 8];
                end
                rd_q <= mem_q[rd_idx];
            end

            assign rd_word[8*gi +: 8] = rd_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read formatting (little-endian lanes)
    // ------------------------------------------------------------------
    always_comb begin
        case (lane_q)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];

        case (size_q)
            2'b00:   rd_fmt = {{24{sext_q & rd_byte[7]}}, rd_byte};
            2'b01:   rd_fmt = {{16{sext_q & rd_half[15]}}, rd_half};
            2'b10:   rd_fmt = rd_word;
            default: rd_fmt = 32'd0;
        endcase
        if (err_q) begin
            rd_fmt = 32'd0;
        end
    end

    assign rd_present = (state_q == S_DONE) && (err_q || !we_q);

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rdata    = rd_present ? rd_fmt : rdata_q;
    assign ready    = (state_q == S_DONE);
    assign busy     = (state_q != S_IDLE);
    assign addr_err = (state_q == S_DONE) && err_q;
    assign word_idx = word_idx_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Scoreboard testbench for dmem_ctrl. Each access pushes its expected
// completion (rdata, addr_err, word_idx) into a queue. The monitor pops the
// queue and compares every time ready is seen. The stimulus side checks
// latency, busy, err_cnt and reset behaviour directly.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

    localparam int WAIT = 1;
    localparam int AW   = 11;

    typedef struct {
        logic [31:0]   rdata;
        logic          err;
        logic [AW-1:0] idx;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic [1:0]    size = 2'b00;
    logic          sign_ext = 1'b0;
    logic [31:0]   addr = 32'd0;
    logic [31:0]   wdata = 32'd0;
    logic [31:0]   rdata;
    logic          ready;
    logic          busy;
    logic          addr_err;
    logic [AW-1:0] word_idx;
    logic [7:0]    err_cnt;

    int   checks   = 0;
    int   failures = 0;
    int   rdy_cnt  = 0;
    bit   mon_en   = 1'b0;
    exp_t sb[$];

    dmem_ctrl #(
        .DATA_W      (32),
        .DEPTH_WORDS (2048),
        .BASE_ADDR   (32'h1001_0000),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .size     (size),
        .sign_ext (sign_ext),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .ready    (ready),
        .busy     (busy),
        .addr_err (addr_err),
        .word_idx (word_idx),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req_v);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ready) begin
                rdy_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ready: got ready=1 expected no completion (rdata=0x%08h)", rdata);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("txn: rdata=0x%08h addr_err=%0b word_idx=%0d (exp 0x%08h %0b %0d)",
                             rdata, addr_err, word_idx, e.rdata, e.err, e.idx);
                    check("mon_rdata", rdata, e.rdata);
                    check("mon_addr_err", {31'd0, addr_err}, {31'd0, e.err});
                    check("mon_word_idx", {21'd0, word_idx}, {21'd0, e.idx});
                end
            end else begin
                check("mon_err_idle", {31'd0, addr_err}, 32'd0);
            end
        end
    end

    // Issue one access and wait for its completion. The expected latency is
    // WAIT+1 falling edges after the accept edge. busy must be high on the
    // first of those edges.
    task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] er, input logic ee, input logic [AW-1:0] ei);
        exp_t e;
        int   lat;
        e.rdata = er;
        e.err   = ee;
        e.idx   = ei;
        sb.push_back(e);
        @(negedge clk);
        req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("busy_in_flight", {31'd0, busy}, 32'd1);
            if (ready) break;
        end
        check("latency", lat, WAIT + 1);
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_addr_err", {31'd0, addr_err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_word_idx", {21'd0, word_idx}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Basic word write/read and extension
        access(1'b1, 2'b10, 1'b0, 32'h1001_0000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 11'd0);
        access(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0,         32'hDEAD_BEEF, 1'b0, 11'd0);
        access(1'b0, 2'b00, 1'b1, 32'h1001_0003, 32'h0,         32'hFFFF_FFDE, 1'b0, 11'd0);
        access(1'b0, 2'b00, 1'b0, 32'h1001_0003, 32'h0,         32'h0000_00DE, 1'b0, 11'd0);

        // Byte write into lane 1 leaves other lanes, rdata holds across writes
        access(1'b1, 2'b00, 1'b0, 32'h1001_0001, 32'hAAAA_AA55, 32'h0000_00DE, 1'b0, 11'd0);
        access(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0,         32'hDEAD_55EF, 1'b0, 11'd0);
        access(1'b0, 2'b01, 1'b1, 32'h1001_0002, 32'h0,         32'hFFFF_DEAD, 1'b0, 11'd0);
        access(1'b0, 2'b01, 1'b0, 32'h1001_0000, 32'h0,         32'h0000_55EF, 1'b0, 11'd0);
        access(1'b1, 2'b10, 1'b0, 32'h1001_0010, 32'h0BAD_F00D, 32'h0000_55EF, 1'b0, 11'd4);

        // Rejected accesses
        access(1'b1, 2'b01, 1'b0, 32'h1001_0001, 32'hFFFF_FFFF, 32'h0, 1'b1, 11'd0);
        access(1'b0, 2'b10, 1'b0, 32'h1001_2000, 32'h0,         32'h0, 1'b1, 11'd0);
        access(1'b0, 2'b10, 1'b0, 32'h1000_FFFC, 32'h0,         32'h0, 1'b1, 11'h7FF);
        access(1'b0, 2'b11, 1'b0, 32'h1001_0004, 32'h0,         32'h0, 1'b1, 11'd1);
        @(negedge clk);
        check("err_cnt_after_4", {24'd0, err_cnt}, 32'd4);
        access(1'b0, 2'b10, 1'b0, 32'h1001_0000, 32'h0,         32'hDEAD_55EF, 1'b0, 11'd0);

        // req held high: one access per WAIT+2 cycles, nothing queued
        begin
            exp_t e;
            int   snap;
            e.rdata = 32'hDEAD_55EF; e.err = 1'b0; e.idx = 11'd0;
            repeat (3) sb.push_back(e);
            @(negedge clk);
            snap = rdy_cnt;
            req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h1001_0000;
            repeat (9) @(negedge clk);
            #1 req = 1'b0;
            check("held_req_readies", rdy_cnt - snap, 3);
            @(negedge clk);
        end

        // Reset during WAIT of a write aborts it
        begin
            int snap;
            @(negedge clk);
            req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h1001_0010; wdata = 32'h1234_5678;
            @(posedge clk);
            #1 req = 1'b0;
            @(negedge clk);
            check("busy_before_abort", {31'd0, busy}, 32'd1);
            rst = 1'b0;
            @(negedge clk);
            rst = 1'b1;
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_err_cnt", {24'd0, err_cnt}, 32'd0);
            check("abort_word_idx", {21'd0, word_idx}, 32'd0);
            check("abort_rdata", rdata, 32'd0);
            snap = rdy_cnt;
            repeat (4) @(negedge clk);
            check("abort_no_ready", rdy_cnt - snap, 0);
        end
        access(1'b0, 2'b10, 1'b0, 32'h1001_0010, 32'h0, 32'h0BAD_F00D, 1'b0, 11'd4);

        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
